// File: rtl/datapath_pkg.sv
// Shared types for the scalar data-memory controller: queued request entry and FSM states.
package datapath_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  typedef struct packed {
    logic             ren;
    logic             wen;
    logic             err;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } ctrl_state_t;

  // A request is rejected if it is not word aligned or asks for load and store at once.
  function automatic logic req_is_bad(logic ren, logic wen, logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00) || (ren && wen);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy; push is refused when full, pop when empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  // Full/empty come from the registered count only, so there is no same-cycle bypass.
  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and count update; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/scalar_dmem_ctrl.sv
// Queues FU load/store requests, issues them to the data cache in order, returns one-cycle hits.
module scalar_dmem_ctrl
  import datapath_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              req_ready,
  output logic [DATA_W-1:0] dmem_in,
  output logic              dhit_in,
  output logic              dmem_err,
  output logic              dc_ren,
  output logic              dc_wen,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic [DATA_W-1:0] dc_rdata,
  input  logic              dc_hit
);

  ctrl_state_t       state_q;
  dmem_req_t         enq_req, head;
  logic              fifo_full, fifo_empty, pop;
  logic              dc_ren_q, dc_wen_q, dhit_q, err_q;
  logic [ADDR_W-1:0] dc_addr_q;
  logic [DATA_W-1:0] dc_wdata_q, rdata_q;

  assign enq_req = '{
    ren:   dmemREN,
    wen:   dmemWEN,
    err:   req_is_bad(dmemREN, dmemWEN, dmemaddr[1:0]),
    addr:  dmemaddr,
    wdata: dmemstore
  };

  // The head leaves the queue when its access completes, or immediately if it was rejected.
  assign pop = (state_q == StIssue) && (head.err || dc_hit);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(dmem_req_t))
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .flush_i (flush),
    .push_i  (dmemREN || dmemWEN),
    .wdata_i (enq_req),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Control FSM; strobes are loaded from the head on entry to StIssue and held until dc_hit.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      state_q    <= StIdle;
      dc_ren_q   <= 1'b0;
      dc_wen_q   <= 1'b0;
      dc_addr_q  <= '0;
      dc_wdata_q <= '0;
      dhit_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q    <= StIssue;
            dc_ren_q   <= head.ren && !head.err;
            dc_wen_q   <= head.wen && !head.err;
            dc_addr_q  <= head.addr;
            dc_wdata_q <= head.wdata;
          end
        end
        StIssue: begin
          if (head.err) begin
            state_q <= StResp;
            dhit_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (dc_hit) begin
            state_q  <= StResp;
            dc_ren_q <= 1'b0;
            dc_wen_q <= 1'b0;
            dhit_q   <= 1'b1;
            err_q    <= 1'b0;
            rdata_q  <= head.ren ? dc_rdata : '0;
          end
        end
        StResp: begin
          dhit_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          if (!fifo_empty) begin
            state_q    <= StIssue;
            dc_ren_q   <= head.ren && !head.err;
            dc_wen_q   <= head.wen && !head.err;
            dc_addr_q  <= head.addr;
            dc_wdata_q <= head.wdata;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = !fifo_full;
  assign dc_ren    = dc_ren_q;
  assign dc_wen    = dc_wen_q;
  assign dc_addr   = dc_addr_q;
  assign dc_wdata  = dc_wdata_q;
  assign dhit_in   = dhit_q;
  assign dmem_err  = err_q;
  assign dmem_in   = rdata_q;

endmodule

// File: tb/tb_scalar_dmem_ctrl.sv
// Directed bench for scalar_dmem_ctrl with an in-order response scoreboard.
module tb_scalar_dmem_ctrl;

  localparam logic [31:0] Magic = 32'hA5A5_0000;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST, flush, dmemREN, dmemWEN, dc_hit;
  logic [31:0] dmemaddr, dmemstore, dc_rdata;
  logic        req_ready, dhit_in, dmem_err, dc_ren, dc_wen;
  logic [31:0] dmem_in, dc_addr, dc_wdata;

  int   checks = 0;
  int   errors = 0;
  int   dhit_cnt = 0;
  logic prev_dhit = 1'b0;
  logic strobe_seen = 1'b0;
  exp_t sb[$];

  scalar_dmem_ctrl #(
    .DEPTH  (4),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .req_ready (req_ready),
    .dmem_in   (dmem_in),
    .dhit_in   (dhit_in),
    .dmem_err  (dmem_err),
    .dc_ren    (dc_ren),
    .dc_wen    (dc_wen),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_rdata  (dc_rdata),
    .dc_hit    (dc_hit)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample at the falling edge and score any completion.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    @(negedge CLK);
    if (dc_ren || dc_wen) strobe_seen = 1'b1;
    if (dhit_in) begin
      dhit_cnt++;
      chk("dhit_single_cycle", prev_dhit, 1'b0);
      if (sb.size() == 0) begin
        chk("unexpected_dhit", dhit_in, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("dmem_in", dmem_in, e.data);
        chk("dmem_err", dmem_err, e.err);
      end
    end
    prev_dhit = dhit_in;
  endtask

  task automatic req(input logic ren, input logic wen, input logic [31:0] addr,
                     input logic [31:0] data, input exp_t e, input logic exp_ready);
    chk("req_ready", req_ready, exp_ready);
    dmemREN   = ren;
    dmemWEN   = wen;
    dmemaddr  = addr;
    dmemstore = data;
    if (exp_ready) sb.push_back(e);
    tick();
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  task automatic drain(input int max_cycles, input logic hit_en);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      dc_hit   = hit_en;
      dc_rdata = dc_addr ^ Magic;
      tick();
      n++;
    end
    dc_hit = 1'b0;
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_dc_ren"}, dc_ren, 1'b0);
    chk({tag, "_dc_wen"}, dc_wen, 1'b0);
    chk({tag, "_dhit_in"}, dhit_in, 1'b0);
    chk({tag, "_dmem_in"}, dmem_in, 32'h0);
    chk({tag, "_dmem_err"}, dmem_err, 1'b0);
  endtask

  initial begin
    int base;
    RST = 1'b1; flush = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dc_hit = 1'b0;
    dmemaddr = '0; dmemstore = '0; dc_rdata = '0;
    tick(); tick();
    RST = 1'b0;
    check_idle_outputs("reset");
    chk("reset_dc_addr", dc_addr, 32'h0);

    // 1: load with three wait cycles
    req(1'b1, 1'b0, 32'h100, 32'h0, '{err: 1'b0, data: 32'hDEAD_BEEF}, 1'b1);
    chk("t1_idle_no_strobe", dc_ren, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_dc_ren_held", dc_ren, 1'b1);
      chk("t1_dc_addr", dc_addr, 32'h100);
    end
    dc_hit = 1'b1; dc_rdata = 32'hDEAD_BEEF;
    base = dhit_cnt;
    tick();
    dc_hit = 1'b0;
    chk("t1_dhit_next_cycle", dhit_cnt - base, 1);
    chk("t1_ren_dropped", dc_ren, 1'b0);
    tick();
    chk("t1_dhit_done", dhit_in, 1'b0);

    // 2: store completing on the first strobe cycle
    req(1'b0, 1'b1, 32'h204, 32'h1234_5678, '{err: 1'b0, data: 32'h0}, 1'b1);
    tick();
    chk("t2_dc_wen", dc_wen, 1'b1);
    chk("t2_dc_ren", dc_ren, 1'b0);
    chk("t2_dc_addr", dc_addr, 32'h204);
    chk("t2_dc_wdata", dc_wdata, 32'h1234_5678);
    dc_hit = 1'b1; dc_rdata = 32'hFFFF_FFFF;
    base = dhit_cnt;
    tick();
    dc_hit = 1'b0;
    chk("t2_dhit", dhit_cnt - base, 1);
    tick();

    // 3: fill the queue, fifth request refused, then in-order drain
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0,
          '{err: 1'b0, data: (32'h40 + 32'(4 * i)) ^ Magic}, i < 4);
    end
    chk("t3_full_ready", req_ready, 1'b0);
    base = dhit_cnt;
    drain(40, 1'b1);
    chk("t3_dhit_count", dhit_cnt - base, 4);
    tick();

    // 4: misaligned load and REN+WEN request are rejected without touching the cache
    strobe_seen = 1'b0;
    req(1'b1, 1'b0, 32'h102, 32'h0, '{err: 1'b1, data: 32'h0}, 1'b1);
    req(1'b1, 1'b1, 32'h200, 32'h5555_5555, '{err: 1'b1, data: 32'h0}, 1'b1);
    drain(20, 1'b0);
    tick();
    chk("t4_no_strobe", strobe_seen, 1'b0);

    // 5: flush with a head in ISSUE and three behind it, concurrent dc_hit
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, '{err: 1'b0, data: 32'h0}, 1'b1);
    end
    chk("t5_in_issue", dc_ren, 1'b1);
    flush = 1'b1; dc_hit = 1'b1; dc_rdata = 32'h0BAD_0BAD;
    sb.delete();
    tick();
    flush = 1'b0; dc_hit = 1'b0;
    check_idle_outputs("t5_flush");
    for (int i = 0; i < 4; i++) tick();
    chk("t5_still_idle", dc_ren, 1'b0);
    req(1'b1, 1'b0, 32'h400, 32'h0, '{err: 1'b0, data: 32'h400 ^ Magic}, 1'b1);
    drain(20, 1'b1);
    tick();

    // 6: reset while a load is in ISSUE
    req(1'b1, 1'b0, 32'h500, 32'h0, '{err: 1'b0, data: 32'h0}, 1'b1);
    req(1'b1, 1'b0, 32'h504, 32'h0, '{err: 1'b0, data: 32'h0}, 1'b1);
    chk("t6_in_issue", dc_ren, 1'b1);
    RST = 1'b1; dc_hit = 1'b1;
    sb.delete();
    tick();
    RST = 1'b0;
    check_idle_outputs("t6_reset");
    strobe_seen = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    dc_hit = 1'b0;
    chk("t6_no_strobe_after", strobe_seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
